// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB next-PC predictor with 2-bit counters and perf stats
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = 30 - IDX_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    input  logic        fetch_valid,
    input  logic        stall,
    output logic        prediction,
    output logic [31:0] control_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] stat_lookups,
    output logic [31:0] stat_mispredicts
);

    logic             valid_q [ENTRIES];
    logic [1:0]       ctr_q   [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [31:0]      tgt_q   [ENTRIES];
    logic [31:0]      lookups_q;
    logic [31:0]      mispredicts_q;

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic             unused_bits;

    // PC[1:0] never participates in indexing or tagging
    assign unused_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

    assign f_idx = fetch_pc[IDX_W+1:2];
    assign f_tag = fetch_pc[31:IDX_W+2];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[31:IDX_W+2];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    // Zero-latency lookup; reset forces a fall-through prediction
    always_comb begin
        f_hit      = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        prediction = !rst && f_hit && ctr_q[f_idx][1];
        control_pc = prediction ? tgt_q[f_idx] : fetch_pc + 32'd4;
    end

    // A wrong direction, or a right "taken" with the wrong target, counts as a mispredict
    assign mispredict = upd_valid &&
                        ((upd_taken != upd_pred_taken) ||
                         (upd_taken && upd_pred_taken && (upd_pred_target != upd_target)));

    // Valid bits and direction counters: cold on reset, trained by resolved branches
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (upd_valid) begin
            if (u_hit) begin
                if (upd_taken) begin
                    if (ctr_q[u_idx] != 2'b11) ctr_q[u_idx] <= ctr_q[u_idx] + 2'd1;
                end else begin
                    if (ctr_q[u_idx] != 2'b00) ctr_q[u_idx] <= ctr_q[u_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                valid_q[u_idx] <= 1'b1;
                ctr_q[u_idx]   <= 2'b10;
            end
        end
    end

    // Tag and target payload; a taken update either refreshes a hit or allocates over a miss
    always_ff @(posedge clk) begin
        if (!rst && upd_valid && upd_taken) begin
            tag_q[u_idx] <= u_tag;
            tgt_q[u_idx] <= upd_target;
        end
    end

    // Saturating perf counters
    always_ff @(posedge clk) begin
        if (rst) begin
            lookups_q     <= 32'd0;
            mispredicts_q <= 32'd0;
        end else begin
            if (fetch_valid && !stall && (lookups_q != 32'hFFFF_FFFF))
                lookups_q <= lookups_q + 32'd1;
            if (mispredict && (mispredicts_q != 32'hFFFF_FFFF))
                mispredicts_q <= mispredicts_q + 32'd1;
        end
    end

    assign stat_lookups     = lookups_q;
    assign stat_mispredicts = mispredicts_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic        stall;
    logic        prediction;
    logic [31:0] control_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] stat_lookups;
    logic [31:0] stat_mispredicts;

    int total = 0;
    int bad   = 0;

    branch_predictor #(.ENTRIES(16)) dut (
        .clk(clk),
        .rst(rst),
        .fetch_pc(fetch_pc),
        .fetch_valid(fetch_valid),
        .stall(stall),
        .prediction(prediction),
        .control_pc(control_pc),
        .upd_valid(upd_valid),
        .upd_pc(upd_pc),
        .upd_taken(upd_taken),
        .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target),
        .mispredict(mispredict),
        .stat_lookups(stat_lookups),
        .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic pt, input logic [31:0] ptgt);
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_taken       = tk;
        upd_target      = tgt;
        upd_pred_taken  = pt;
        upd_pred_target = ptgt;
        tick();
        upd_valid = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic ep, input logic [31:0] ecpc);
        fetch_pc = pc;
        #1;
        chk({tag, "_pred"}, {31'd0, prediction}, {31'd0, ep});
        chk({tag, "_cpc"}, control_pc, ecpc);
    endtask

    initial begin
        rst = 1'b1; fetch_pc = 32'h40; fetch_valid = 1'b0; stall = 1'b0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        upd_pred_taken = 1'b0; upd_pred_target = '0;
        #2;
        chk("rst_pred", {31'd0, prediction}, 32'd0);
        chk("rst_cpc", control_pc, 32'h44);
        tick();
        tick();
        rst = 1'b0;

        // 1: cold lookup, counted
        fetch_valid = 1'b1;
        look("cold", 32'h40, 1'b0, 32'h44);
        chk("stat_lk0", stat_lookups, 32'd0);
        chk("stat_mp0", stat_mispredicts, 32'd0);
        tick();
        fetch_valid = 1'b0;
        chk("stat_lk1", stat_lookups, 32'd1);

        // 2: allocate on taken miss
        upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h100;
        upd_pred_taken = 1'b0; upd_pred_target = 32'h44;
        #1;
        chk("mp_alloc", {31'd0, mispredict}, 32'd1);
        tick();
        upd_valid = 1'b0;
        look("alloc", 32'h40, 1'b1, 32'h100);
        chk("stat_mp1", stat_mispredicts, 32'd1);
        chk("stat_lk_nocount", stat_lookups, 32'd1);

        // 3: counter training and saturation
        upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
        look("nt1", 32'h40, 1'b0, 32'h44);
        upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h44);
        look("nt2", 32'h40, 1'b0, 32'h44);
        upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h44);
        look("nt3", 32'h40, 1'b0, 32'h44);
        upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
        look("t1", 32'h40, 1'b0, 32'h44);
        upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
        look("t2", 32'h40, 1'b1, 32'h100);
        upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
        upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
        upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
        look("sat_hi_nt1", 32'h40, 1'b1, 32'h100);
        upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
        look("sat_hi_nt2", 32'h40, 1'b0, 32'h44);
        chk("stat_mp6", stat_mispredicts, 32'd6);

        // 4: aliasing evicts 0x40
        upd(32'h80, 1'b1, 32'h200, 1'b0, 32'h84);
        look("alias40", 32'h40, 1'b0, 32'h44);
        look("alias80", 32'h80, 1'b1, 32'h200);

        // 5: same-cycle lookup and update sees old contents
        fetch_pc = 32'h40;
        upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h100;
        upd_pred_taken = 1'b0; upd_pred_target = 32'h44;
        #1;
        chk("same_pred", {31'd0, prediction}, 32'd0);
        chk("same_cpc", control_pc, 32'h44);
        tick();
        upd_valid = 1'b0;
        look("after_same", 32'h40, 1'b1, 32'h100);
        upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h180;
        upd_pred_taken = 1'b1; upd_pred_target = 32'h100;
        #1;
        chk("mp_target", {31'd0, mispredict}, 32'd1);
        tick();
        upd_valid = 1'b0;
        look("new_tgt", 32'h40, 1'b1, 32'h180);
        upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h180;
        upd_pred_taken = 1'b1; upd_pred_target = 32'h180;
        #1;
        chk("mp_correct", {31'd0, mispredict}, 32'd0);
        tick();
        upd_valid = 1'b0;
        chk("stat_mp9", stat_mispredicts, 32'd9);
        look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

        // stall suppresses lookup counting
        fetch_valid = 1'b1; stall = 1'b1;
        tick();
        chk("stat_stall", stat_lookups, 32'd1);
        stall = 1'b0; fetch_valid = 1'b0;

        // 6: reset with a pending update
        rst = 1'b1; fetch_valid = 1'b1;
        upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h300;
        upd_pred_taken = 1'b0; upd_pred_target = 32'h104;
        look("in_rst", 32'h40, 1'b0, 32'h44);
        tick();
        rst = 1'b0; upd_valid = 1'b0; fetch_valid = 1'b0;
        chk("rst_lk", stat_lookups, 32'd0);
        chk("rst_mp", stat_mispredicts, 32'd0);
        look("post_rst40", 32'h40, 1'b0, 32'h44);
        look("post_rst80", 32'h80, 1'b0, 32'h84);
        look("post_rst100", 32'h100, 1'b0, 32'h104);

        // stats saturation
        force dut.lookups_q = 32'hFFFF_FFFE;
        force dut.mispredicts_q = 32'hFFFF_FFFE;
        #1;
        release dut.lookups_q;
        release dut.mispredicts_q;
        fetch_valid = 1'b1;
        upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b0; upd_target = 32'h0;
        upd_pred_taken = 1'b1; upd_pred_target = 32'h100;
        tick();
        chk("sat_lk1", stat_lookups, 32'hFFFF_FFFF);
        chk("sat_mp1", stat_mispredicts, 32'hFFFF_FFFF);
        tick();
        chk("sat_lk2", stat_lookups, 32'hFFFF_FFFF);
        chk("sat_mp2", stat_mispredicts, 32'hFFFF_FFFF);
        fetch_valid = 1'b0; upd_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
